shared_cache_responder: RTL

//  Responder end of the dual-processor cache request protocol: the shared cache both CPU

---
 rtl/shared_cache_responder_if.sv | 33 +++
 rtl/shared_cache_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/shared_cache_responder_if.sv
// Request/response bus between the two CPU cores and the shared cache responder.
//
// Signals:
//   p0_request     [21:0]  CPU0 request {pid, ld_st, tag[10:0], offset, data[7:0]}
//   p0_valid               CPU0 request present, held until CPU0's response is seen
//   p1_request     [21:0]  CPU1 request, same format
//   p1_valid               CPU1 request present, held until CPU1's response is seen
//   data_out       [21:0]  response {pid, ld_st, tag, offset, data}
//   data_out_valid         one-cycle pulse marking data_out valid
//   is_busy                high from the cycle after grant through the response cycle
//
// Modports:
//   master  - requester side (the CPU cores / testbench)
//   slave   - responder side (the shared cache)
interface shared_cache_responder_if;
  logic [21:0] p0_request;
  logic        p0_valid;
  logic [21:0] p1_request;
  logic        p1_valid;
  logic [21:0] data_out;
  logic        data_out_valid;
  logic        is_busy;

  modport master (
    output p0_request, p0_valid, p1_request, p1_valid,
    input  data_out, data_out_valid, is_busy
  );

  modport slave (
    input  p0_request, p0_valid, p1_request, p1_valid,
    output data_out, data_out_valid, is_busy
  );
endinterface

// File: rtl/shared_cache_responder.sv
// Shared cache responder for two CPU cores. Arbitrates the two request ports
// (round-robin on collisions), looks up a direct-mapped cache of 2**INDEX_BITS
// two-byte lines backed by a 4 KB byte memory, and returns one response word
// per request on the shared data bus.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   reset      synchronous active-high reset
//   bus        shared_cache_responder_if.slave (requests in, response/busy out)
//   hit_count  [15:0] saturating hit counter   (only with CACHE_STATS_EN)
//   miss_count [15:0] saturating miss counter  (only with CACHE_STATS_EN)
//
// Configuration macro: CACHE_STATS_EN adds the hit/miss statistics counters.
//
// Loads are write-through / no-write-allocate for stores; a load miss waits
// MISS_LAT cycles and then fills the whole line from the backing memory.
module shared_cache_responder #(
  parameter int INDEX_BITS = 3,
  parameter int MISS_LAT   = 4
) (
  input  logic clk,
  input  logic reset,
`ifdef CACHE_STATS_EN
  output logic [15:0] hit_count,
  output logic [15:0] miss_count,
`endif
  shared_cache_responder_if.slave bus
);

  localparam int NUM_LINES = 2 ** INDEX_BITS;
  localparam int TAG_W     = 11 - INDEX_BITS;
  localparam int MEM_DEPTH = 4096;
  localparam int CNT_W     = $clog2(MISS_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MISS_WAIT,
    RESPOND
  } state_t;

  state_t state, next_state;

  logic [21:0]            req_q;
  logic                   grant_port;
  logic                   rr_ptr;
  logic [CNT_W-1:0]       miss_cnt;
  logic [NUM_LINES-1:0]   line_valid;
  logic [TAG_W-1:0]       line_tag  [NUM_LINES];
  logic [7:0]             line_data [NUM_LINES][2];
  logic [21:0]            data_out_q;
  logic                   data_out_valid_q;
  logic                   is_busy_q;

  // Backing memory is deliberately not reset; zero at power-up in simulation.
  logic [7:0] backing_mem [MEM_DEPTH] = '{default: 8'h00};

  // Field views of the latched request. The requester's pid bit is ignored:
  // the response carries the granted port number instead.
  logic                  req_st;
  logic [10:0]           req_tag;
  logic                  req_off;
  logic [7:0]            req_data;
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_stag;
  logic [11:0]           req_addr;
  logic                  unused_req_pid;

  assign unused_req_pid = req_q[21];
  assign req_st   = req_q[20];
  assign req_tag  = req_q[19:9];
  assign req_off  = req_q[8];
  assign req_data = req_q[7:0];
  assign req_idx  = req_tag[INDEX_BITS-1:0];
  assign req_stag = req_tag[10:INDEX_BITS];
  assign req_addr = {req_tag, req_off};

  logic hit;
  logic miss_done;
  logic any_valid;
  logic both_valid;
  logic grant_sel;

  assign hit        = line_valid[req_idx] && (line_tag[req_idx] == req_stag);
  assign miss_done  = (miss_cnt == CNT_W'(1));
  assign any_valid  = bus.p0_valid || bus.p1_valid;
  assign both_valid = bus.p0_valid && bus.p1_valid;
  // On a collision the round-robin pointer decides; otherwise the lone requester wins.
  assign grant_sel  = both_valid ? rr_ptr : bus.p1_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (any_valid) next_state = LOOKUP;
      LOOKUP:    next_state = (!req_st && !hit) ? MISS_WAIT : RESPOND;
      MISS_WAIT: if (miss_done) next_state = RESPOND;
      RESPOND:   next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Control/datapath registers. Outputs are registered off next_state so that
  // data_out_valid is high exactly during the RESPOND cycle and is_busy covers
  // LOOKUP through RESPOND.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q            <= '0;
      grant_port       <= 1'b0;
      rr_ptr           <= 1'b0;
      miss_cnt         <= '0;
      line_valid       <= '0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      is_busy_q        <= 1'b0;
    end else begin
      is_busy_q        <= (next_state != IDLE);
      data_out_valid_q <= (next_state == RESPOND);
      case (state)
        IDLE: begin
          if (any_valid) begin
            req_q      <= grant_sel ? bus.p1_request : bus.p0_request;
            grant_port <= grant_sel;
            if (both_valid) rr_ptr <= ~rr_ptr;
          end
        end
        LOOKUP: begin
          if (req_st) begin
            data_out_q <= {grant_port, req_q[20:8], req_data};
          end else if (hit) begin
            data_out_q <= {grant_port, req_q[20:8], line_data[req_idx][req_off]};
          end else begin
            miss_cnt <= CNT_W'(MISS_LAT);
          end
        end
        MISS_WAIT: begin
          if (miss_done) begin
            line_valid[req_idx] <= 1'b1;
            data_out_q <= {grant_port, req_q[20:8], backing_mem[req_addr]};
          end else begin
            miss_cnt <= miss_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Line tag/data storage: store hits update the line byte, load-miss
  // completion refills both bytes. Reset suppresses any write in that cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == LOOKUP && req_st && hit) begin
        line_data[req_idx][req_off] <= req_data;
      end
      if (state == MISS_WAIT && miss_done) begin
        line_tag[req_idx]     <= req_stag;
        line_data[req_idx][0] <= backing_mem[{req_tag, 1'b0}];
        line_data[req_idx][1] <= backing_mem[{req_tag, 1'b1}];
      end
    end
  end

  // Backing memory: every store writes through, hit or miss.
  always_ff @(posedge clk) begin
    if (!reset && state == LOOKUP && req_st) begin
      backing_mem[req_addr] <= req_data;
    end
  end

`ifdef CACHE_STATS_EN
  // Hit/miss statistics, counted once per request in LOOKUP, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (hit) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

  assign bus.data_out       = data_out_q;
  assign bus.data_out_valid = data_out_valid_q;
  assign bus.is_busy        = is_busy_q;

endmodule
